// File: rtl/clk_tick_pkg.sv
// Shared constants for the tick generator: channel mode encoding and channel-count limit.
package clk_tick_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/clk_tick_chan.sv
// One programmable clock-enable channel: first tick is high DIV+1 cycles after its write.
// No backpressure; hold freezes the count and defers a due tick.
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             wr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             cfg_en,
  output logic             tick,
  output logic             active
);

  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] cnt;
  logic             mode;
  logic             en;

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      cnt  <= '0;
      mode <= MODE_PERIODIC;
      en   <= 1'b0;
      tick <= 1'b0;
    end else if (wr) begin
      // A write always restarts the count, discarding any pending tick.
      div  <= cfg_div;
      cnt  <= cfg_div;
      mode <= cfg_mode;
      en   <= cfg_en;
      tick <= 1'b0;
    end else if (hold || !en) begin
      tick <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - WIDTH'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b1;
      if (mode == MODE_PERIODIC) begin
        cnt <= div;
      end else begin
        en <= 1'b0;
      end
    end
  end

  assign active = en;

endmodule

// File: rtl/clk_tick_gen.sv
// Free-running counter plus CHANNELS independent tick channels; counter and ticks are registered.
// No backpressure; hold freezes all counting, config writes still land.
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                cfg_we,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic                cfg_en,
  output logic [WIDTH-1:0]    clk_div_counter,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active
);

  localparam int NCH = (CHANNELS > MAX_CHANNELS) ? MAX_CHANNELS : CHANNELS;

  logic chan_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_div_counter <= '0;
    end else if (!hold) begin
      clk_div_counter <= clk_div_counter + WIDTH'(1);
    end
  end

  // Out-of-range selects are dropped here so no channel ever sees them.
  assign chan_ok = int'(cfg_chan) < NCH;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    if (i < NCH) begin : g_live
      logic wr;
      assign wr = cfg_we && chan_ok && (cfg_chan == CHAN_W'(i));

      clk_tick_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .wr       (wr),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_en   (cfg_en),
        .tick     (tick[i]),
        .active   (active[i])
      );
    end else begin : g_none
      assign tick[i]   = 1'b0;
      assign active[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Randomized and directed bench for clk_tick_gen against an edges-until-tick reference model.
module tb_clk_tick_gen;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int CHAN_W   = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                hold = 1'b0;
  logic                cfg_we = 1'b0;
  logic [CHAN_W-1:0]   cfg_chan = '0;
  logic [WIDTH-1:0]    cfg_div = '0;
  logic                cfg_mode = 1'b0;
  logic                cfg_en = 1'b0;
  logic [WIDTH-1:0]    clk_div_counter;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] active;

  int checks = 0;
  int errors = 0;

  // Reference model: free count, and per channel the number of running edges left until the next tick.
  int m_cnt;
  int m_div  [CHANNELS];
  int m_due  [CHANNELS];
  bit m_en   [CHANNELS];
  bit m_mode [CHANNELS];
  bit m_tick [CHANNELS];

  clk_tick_gen #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CHAN_W   (CHAN_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .cfg_we          (cfg_we),
    .cfg_chan        (cfg_chan),
    .cfg_div         (cfg_div),
    .cfg_mode        (cfg_mode),
    .cfg_en          (cfg_en),
    .clk_div_counter (clk_div_counter),
    .tick            (tick),
    .active          (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_cnt = 0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_div[c] = 0; m_due[c] = 0; m_en[c] = 0; m_mode[c] = 0; m_tick[c] = 0;
      end
    end else begin
      if (!hold) m_cnt = (m_cnt + 1) % (1 << WIDTH);
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && int'(cfg_chan) == c) begin
          m_div[c]  = int'(cfg_div);
          m_due[c]  = int'(cfg_div) + 1;
          m_mode[c] = cfg_mode;
          m_en[c]   = cfg_en;
          m_tick[c] = 0;
        end else if (hold || !m_en[c]) begin
          m_tick[c] = 0;
        end else begin
          m_due[c]--;
          if (m_due[c] == 0) begin
            m_tick[c] = 1;
            if (m_mode[c]) m_en[c] = 0;
            else m_due[c] = m_div[c] + 1;
          end else begin
            m_tick[c] = 0;
          end
        end
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    logic [CHANNELS-1:0] et, ea;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < CHANNELS; c++) begin
      et[c] = m_tick[c];
      ea[c] = m_en[c];
    end
    check("counter", 32'(clk_div_counter), 32'(m_cnt));
    check("tick", 32'(tick), 32'(et));
    check("active", 32'(active), 32'(ea));
  endtask

  task automatic wr_cfg(input int chan, input int div, input bit mode, input bit en);
    cfg_chan = CHAN_W'(chan);
    cfg_div  = WIDTH'(div);
    cfg_mode = mode;
    cfg_en   = en;
    cfg_we   = 1'b1;
    cyc();
    cfg_we   = 1'b0;
  endtask

  initial begin
    // Reset state and free counter, including wrap at 2^WIDTH.
    reset = 1'b1;
    cyc();
    check("rst_cnt", 32'(clk_div_counter), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    check("cnt10", 32'(clk_div_counter), 32'd10);
    check("cnt10_tick", 32'(tick), 32'd0);
    for (int k = 0; k < 6; k++) cyc();
    check("cnt_wrap", 32'(clk_div_counter), 32'd0);

    // Periodic DIV=3 ticks after edges 4, 8, 12.
    wr_cfg(0, 3, 1'b0, 1'b1);
    check("ch0_active", 32'(active[0]), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("ch0_period", 32'(tick[0]), 32'((k % 4) == 0));
    end

    // DIV=0 periodic is high continuously from the edge after the write.
    wr_cfg(1, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("ch1_cont", 32'(tick[1]), 32'd1);
    end

    // One-shot DIV=2: single tick after edge 3, active drops on that edge.
    wr_cfg(2, 2, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("ch2_oneshot", 32'(tick[2]), 32'(k == 3));
      check("ch2_active", 32'(active[2]), 32'(k < 3));
    end

    // Hold over a due tick defers it to the first edge after release.
    wr_cfg(0, 3, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) cyc();
    hold = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      cyc();
      check("hold_tick0", 32'(tick[0]), 32'd0);
    end
    hold = 1'b0;
    for (int k = 9; k <= 13; k++) begin
      cyc();
      check("hold_resume", 32'(tick[0]), 32'(k == 9 || k == 13));
    end

    // Rewrite mid-count restarts; an out-of-range select is ignored.
    cyc();
    wr_cfg(0, 5, 1'b0, 1'b1);
    wr_cfg(7, 1, 1'b1, 1'b0);
    check("inv_active", 32'(active), 32'b0011);
    for (int k = 2; k <= 6; k++) begin
      cyc();
      check("restart_tick0", 32'(tick[0]), 32'(k == 6));
    end

    // Reset mid-count clears everything within the same edge.
    wr_cfg(3, 7, 1'b0, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_cnt", 32'(clk_div_counter), 32'd0);
    reset = 1'b0;
    wr_cfg(3, 4, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("post_rst_tick3", 32'(tick[3]), 32'(k == 5));
    end

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 199) == 0);
      hold     = ($urandom_range(0, 4) == 0);
      cfg_we   = ($urandom_range(0, 6) == 0);
      cfg_chan = CHAN_W'($urandom_range(0, 7));
      cfg_div  = WIDTH'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15));
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_en   = ($urandom_range(0, 5) != 0);
      cyc();
    end
    reset  = 1'b0;
    hold   = 1'b0;
    cfg_we = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
